alu_ex_unit: RTL
================

# alu_ex_unit

Parametrised execute-stage unit for the pipelined CPU. It combines the aluOp/funct decode with the ALU datapath, an iterative unsigned multiply/divide engine, and HI/LO registers. It sits between the ID/EX pipeline register and the EX/MEM stage, and uses a valid/ready handshake on both sides so that multi-cycle operations stall issue.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8, even).
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit accepts operation this cycle
- aluOp  input  2  00 = add (load/store), 01 = sub (branch), 10 = R-type via funct, 11 = or (ori)
- funct  input  6  MIPS funct field; used only when aluOp = 10
- srcA  input  WIDTH  rs operand
- srcB  input  WIDTH  rt operand or extended immediate
- shamt  input  SHAMT_W  shift amount
- out_valid  output  1  result registered and valid
- out_ready  input  1  downstream consumes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow on add/sub
- illegal  output  1  unrecognised funct
- busy  output  1  multiply/divide iteration in progress

## Operation
- R-type funct codes: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 000000 sll, 000010 srl, 000011 sra, 010000 mfhi, 010010 mflo, 011001 multu, 011011 divu.
- Shifts operate on srcB by shamt. sra is sign-filling.
- overflow is set only for add, sub, aluOp 00 and aluOp 01, using two's-complement signed overflow. The result still wraps modulo 2^WIDTH; there is no trap.
- Any other funct with aluOp = 10 gives result = 0 and illegal = 1, and still completes with out_valid. HI/LO are untouched.
- FSM states: IDLE and MD_RUN.
  - IDLE: an operation is accepted when in_valid && in_ready. Single-cycle operations load the output register on that edge.
  - multu/divu latch the operands, clear the iteration counter and go to MD_RUN.
- MD_RUN runs exactly WIDTH iterations, one per cycle:
  - multu uses shift-add and produces the 2·WIDTH-bit product: HI = upper half, LO = lower half.
  - divu uses restoring division: LO = quotient, HI = remainder.
- On the last iteration, HI/LO and the output register are written, with result = new LO and flags = 0. The FSM then returns to IDLE.
- Divide by zero: after the full WIDTH cycles, HI = srcA and LO = all ones. illegal is not set.
- mfhi/mflo return the HI/LO value committed by the most recent completed multu/divu.

## Timing
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational from state, out_valid and out_ready only, never from in_valid.
- Single-cycle operation latency: out_valid rises 1 cycle after acceptance.
- multu/divu latency: out_valid rises WIDTH + 1 cycles after acceptance. busy is high for exactly WIDTH cycles, starting the cycle after acceptance.
- Backpressure: while out_valid && !out_ready, result and all flags hold stable. out_valid drops the cycle after the handshake unless a new operation was accepted in the same cycle.
- Simultaneous consume and accept in IDLE is allowed: back-to-back single-cycle operations sustain 1 per cycle.
- When MD_RUN completes while the previous result is still unconsumed, the unit does not leave MD_RUN. It holds the final-iteration state, and busy stays high, until out_ready frees the register.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, overflow 0, illegal 0, busy 0, HI 0, LO 0, counter 0.
- Reset mid-MD_RUN aborts the operation. HI/LO remain 0 and no out_valid is produced.

## Test plan
- aluOp = 10, funct = 100000, srcA = 7FFFFFFF, srcB = 1 -> after 1 cycle: result 80000000, overflow 1, zero 0. Same operands with addu -> overflow 0.
- aluOp = 01, srcA = srcB = 12345678 -> result 0, zero 1. slt with srcA = FFFFFFFF, srcB = 1 -> result 1. sltu with the same operands -> result 0.
- sra, srcB = 80000000, shamt = 4 -> result F8000000. srl with the same operands -> result 08000000.
- multu, srcA = FFFFFFFF, srcB = 2 -> in_ready low and busy high for 32 cycles, out_valid at cycle 33 with result FFFFFFFE. Then mfhi -> 00000001.
- divu, srcA = 100, srcB = 7 -> LO = 36 (0x24), HI = 4. divu by 0 with srcA = 55 -> LO = FFFFFFFF, HI = 55.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles -> result stable and in_ready 0.
  - funct = 111111 -> illegal 1, result 0.
  - Assert reset at MD_RUN cycle 10 -> next cycle: busy 0, out_valid 0, mfhi returns 0.

Source files
------------

// File: rtl/alu_ex_unit.sv
// rtl/alu_ex_unit.sv - execute-stage ALU with iterative multu/divu engine and HI/LO registers
module alu_ex_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluOp,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal,
    output logic               busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] MD_RUN = 1'b1;

    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic [0:0]         state;
    logic [SHAMT_W-1:0] cnt;
    logic               md_div;
    logic [WIDTH-1:0]   md_d;
    logic [WIDTH-1:0]   hw;
    logic [WIDTH-1:0]   lw;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               accept;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               add_ovf;
    logic               sub_ovf;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic               op_md;
    logic               op_div;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_df;
    logic [WIDTH-1:0]   nxt_hw;
    logic [WIDTH-1:0]   nxt_lw;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MD_RUN);

    assign sum     = srcA + srcB;
    assign diff    = srcA - srcB;
    assign add_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
    assign sub_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        op_md   = 1'b0;
        op_div  = 1'b0;
        case (aluOp)
            2'b00: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            2'b01: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            2'b11: alu_res = srcA | srcB;
            default: begin
                case (funct)
                    F_ADD: begin
                        alu_res = sum;
                        alu_ovf = add_ovf;
                    end
                    F_ADDU: alu_res = sum;
                    F_SUB: begin
                        alu_res = diff;
                        alu_ovf = sub_ovf;
                    end
                    F_SUBU:  alu_res = diff;
                    F_AND:   alu_res = srcA & srcB;
                    F_OR:    alu_res = srcA | srcB;
                    F_XOR:   alu_res = srcA ^ srcB;
                    F_NOR:   alu_res = ~(srcA | srcB);
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
                    F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
                    F_SLL:   alu_res = srcB << shamt;
                    F_SRL:   alu_res = srcB >> shamt;
                    F_SRA:   alu_res = $signed(srcB) >>> shamt;
                    F_MFHI:  alu_res = hi;
                    F_MFLO:  alu_res = lo;
                    F_MULTU: op_md = 1'b1;
                    F_DIVU: begin
                        op_md  = 1'b1;
                        op_div = 1'b1;
                    end
                    default: alu_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Multiply: hw holds the running upper half, lw the multiplier shifting out into the low half.
    // Divide: hw holds the remainder, lw the dividend shifting out while quotient bits shift in.
    always_comb begin
        mul_sum = {1'b0, hw} + (lw[0] ? {1'b0, md_d} : {(WIDTH+1){1'b0}});
        div_rs  = {hw, lw[WIDTH-1]};
        div_df  = div_rs - {1'b0, md_d};
        if (md_div) begin
            nxt_hw = div_df[WIDTH] ? div_rs[WIDTH-1:0] : div_df[WIDTH-1:0];
            nxt_lw = {lw[WIDTH-2:0], ~div_df[WIDTH]};
        end else begin
            nxt_hw = mul_sum[WIDTH:1];
            nxt_lw = {mul_sum[0], lw[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            md_div    <= 1'b0;
            md_d      <= '0;
            hw        <= '0;
            lw        <= '0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_md) begin
                            state  <= MD_RUN;
                            cnt    <= '0;
                            md_div <= op_div;
                            md_d   <= op_div ? srcB : srcA;
                            hw     <= '0;
                            lw     <= op_div ? srcA : srcB;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            illegal   <= alu_ill;
                        end
                    end
                end
                MD_RUN: begin
                    if (cnt != LAST_ITER) begin
                        hw  <= nxt_hw;
                        lw  <= nxt_lw;
                        cnt <= cnt + SHAMT_W'(1);
                    end else if (!out_valid || out_ready) begin
                        // Final iteration commits only once the output register is free.
                        hw        <= nxt_hw;
                        lw        <= nxt_lw;
                        hi        <= nxt_hw;
                        lo        <= nxt_lw;
                        out_valid <= 1'b1;
                        result    <= nxt_lw;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
